// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle ROM interface, branch-target LUT redirect, start/done framing.
// Optional FETCH_PERF_EN adds saturating retired/bubble counters.
module fetch_unit #(
  parameter int                 PC_W      = 10,
  parameter int                 INSTR_W   = 9,
  parameter int                 LUT_IDX_W = 4,
  parameter logic [INSTR_W-1:0] HALT_WORD = 9'b111_11_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  output logic [PC_W-1:0]      o_imem_addr,
  input  logic [INSTR_W-1:0]   i_imem_rdata,
  output logic [INSTR_W-1:0]   o_instr,
  output logic                 o_instr_valid,
  output logic [PC_W-1:0]      o_instr_pc,
  input  logic                 i_branch,
  input  logic [LUT_IDX_W-1:0] i_pc_immed,
  input  logic                 i_lut_we,
  input  logic [LUT_IDX_W-1:0] i_lut_waddr,
  input  logic [PC_W-1:0]      i_lut_wdata,
`ifdef FETCH_PERF_EN
  output logic [15:0]          o_retired_cnt,
  output logic [15:0]          o_bubble_cnt,
`endif
  output logic                 o_done
);

  localparam int              LUT_N  = 2 ** LUT_IDX_W;
  localparam logic [PC_W-1:0] PC_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_fetch_pc;
  logic [PC_W-1:0]   r_instr_pc;
  logic              r_instr_valid;
  logic              r_done;
  logic [PC_W-1:0]   r_lut [LUT_N];

  logic              w_halt;
  logic [PC_W-1:0]   w_target;
  logic              w_start_acc;

  // Halt is recognised on opcode+funct only; the low nibble is don't-care.
  assign w_halt      = (i_imem_rdata[INSTR_W-1:INSTR_W-5] == HALT_WORD[INSTR_W-1:INSTR_W-5]);
  assign w_target    = r_lut[i_pc_immed];
  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign o_imem_addr   = r_fetch_pc;
  assign o_instr       = i_imem_rdata;
  assign o_instr_valid = r_instr_valid;
  assign o_instr_pc    = r_instr_pc;
  assign o_done        = r_done;

  // Combinational read sees the pre-edge entry, so a same-cycle write never affects the branch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LUT_N; i++) r_lut[i] <= '0;
    end else if (i_lut_we) begin
      r_lut[i_lut_waddr] <= i_lut_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_PRIME;
        end
        S_PRIME: begin
          r_fetch_pc    <= r_fetch_pc + PC_ONE;
          r_instr_pc    <= r_fetch_pc;
          r_instr_valid <= 1'b1;
          r_state       <= S_RUN;
        end
        S_RUN: begin
          if (w_halt) begin
            r_instr_valid <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else if (i_branch) begin
            r_fetch_pc    <= w_target;
            r_instr_valid <= 1'b0;
            r_state       <= S_FLUSH;
          end else begin
            r_fetch_pc <= r_fetch_pc + PC_ONE;
            r_instr_pc <= r_fetch_pc;
          end
        end
        // The ROM word arriving now belongs to the old path; the target word arrives next cycle.
        S_FLUSH: begin
          r_instr_pc    <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + PC_ONE;
          r_instr_valid <= 1'b1;
          r_state       <= S_RUN;
        end
        S_DONE: begin
          if (i_start) begin
            r_fetch_pc <= '0;
            r_done     <= 1'b0;
            r_state    <= S_PRIME;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_retired_cnt;
  logic [15:0] r_bubble_cnt;

  assign o_retired_cnt = r_retired_cnt;
  assign o_bubble_cnt  = r_bubble_cnt;

  // Every RUN cycle presents a live instruction, including the halt itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired_cnt <= '0;
      r_bubble_cnt  <= '0;
    end else if (w_start_acc) begin
      r_retired_cnt <= '0;
      r_bubble_cnt  <= '0;
    end else begin
      if ((r_state == S_RUN) && (r_retired_cnt != 16'hFFFF))
        r_retired_cnt <= r_retired_cnt + 16'd1;
      if ((r_state == S_FLUSH) && (r_bubble_cnt != 16'hFFFF))
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_start_acc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: synchronous ROM model plus a tiny decoder model.
// Branch encoding used here: instr[8:5]=1010, instr[4]=taken, instr[3:0]=LUT index.
module tb_fetch_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [9:0]  o_imem_addr;
  logic [8:0]  r_imem_rdata;
  logic [8:0]  o_instr;
  logic        o_instr_valid;
  logic [9:0]  o_instr_pc;
  logic        w_branch;
  logic [3:0]  w_pc_immed;
  logic        i_lut_we;
  logic [3:0]  i_lut_waddr;
  logic [9:0]  i_lut_wdata;
  logic        o_done;
`ifdef FETCH_PERF_EN
  logic [15:0] o_retired_cnt;
  logic [15:0] o_bubble_cnt;
`endif

  logic [8:0] rom [1024];

  typedef struct {
    logic [9:0] pc;
    logic [8:0] instr;
    int         gap;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   gapCnt = 0;

  fetch_unit dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .o_imem_addr   (o_imem_addr),
    .i_imem_rdata  (r_imem_rdata),
    .o_instr       (o_instr),
    .o_instr_valid (o_instr_valid),
    .o_instr_pc    (o_instr_pc),
    .i_branch      (w_branch),
    .i_pc_immed    (w_pc_immed),
    .i_lut_we      (i_lut_we),
    .i_lut_waddr   (i_lut_waddr),
    .i_lut_wdata   (i_lut_wdata),
`ifdef FETCH_PERF_EN
    .o_retired_cnt (o_retired_cnt),
    .o_bubble_cnt  (o_bubble_cnt),
`endif
    .o_done        (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ROM with one cycle of read latency
  always @(posedge i_clk) r_imem_rdata <= rom[o_imem_addr];

  // Decoder model; deliberately not gated by valid so wrong-path branches must be ignored by the DUT
  assign w_branch   = (o_instr[8:5] == 4'b1010) && o_instr[4];
  assign w_pc_immed = o_instr[3:0];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [9:0] pc, input logic [8:0] instr, input int gap);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.gap   = gap;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("doneReached", {31'd0, o_done}, 32'd1);
  endtask

  task automatic waitValidPc(input logic [9:0] pc, input int budget);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge i_clk);
      n++;
      hit = o_instr_valid && (o_instr_pc == pc);
    end
    checkOutput("reachPc", {31'd0, hit}, 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("queueDrained", expQ.size(), 32'd0);
  endtask

  task automatic writeLut(input logic [3:0] idx, input logic [9:0] val);
    @(negedge i_clk);
    i_lut_we    = 1'b1;
    i_lut_waddr = idx;
    i_lut_wdata = val;
    @(negedge i_clk);
    i_lut_we    = 1'b0;
  endtask

  // Monitor: pops one expected instruction per live decoder cycle and checks the bubble gap before it
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_instr_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedInstr: got pc 0x%0h instr 0x%0h with no expected entry", o_instr_pc, o_instr);
        end else begin
          e = expQ.pop_front();
          checkOutput("instrPc", {22'd0, o_instr_pc}, {22'd0, e.pc});
          checkOutput("instrWord", {23'd0, o_instr}, {23'd0, e.instr});
          if (e.gap >= 0) checkOutput("bubbleGap", gapCnt, e.gap);
        end
        gapCnt = 0;
      end else begin
        gapCnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'h000;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_lut_we = 1'b0;
    i_lut_waddr = '0;
    i_lut_wdata = '0;
    #12;
    checkOutput("rstValid", {31'd0, o_instr_valid}, 32'd0);
    checkOutput("rstDone", {31'd0, o_done}, 32'd0);
    checkOutput("rstAddr", {22'd0, o_imem_addr}, 32'd0);
    checkOutput("rstInstrPc", {22'd0, o_instr_pc}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Straight-line program ending in halt
    rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h1F0;
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h033, 0);
    pushExp(10'h003, 9'h1F0, 0);
    applyStimulus();
    repeat (4) @(negedge i_clk);
    checkOutput("doneCycle5", {31'd0, o_done}, 32'd0);
    @(negedge i_clk);
    checkOutput("doneCycle6", {31'd0, o_done}, 32'd1);
    checkOutput("haltAddr", {22'd0, o_imem_addr}, 32'h004);
    repeat (3) @(negedge i_clk);
    checkOutput("frozenAddr", {22'd0, o_imem_addr}, 32'h004);
    checkOutput("doneInvalid", {31'd0, o_instr_valid}, 32'd0);
    waitDrain(5);

    // Taken branch with a halt on the squashed wrong path
    writeLut(4'd5, 10'h040);
    rom[2] = 9'h155; rom[3] = 9'h1F0; rom[10'h040] = 9'h044; rom[10'h041] = 9'h1F0;
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h155, 0);
    pushExp(10'h040, 9'h044, 1);
    pushExp(10'h041, 9'h1F0, 0);
    applyStimulus();
    waitDone(40);
    waitDrain(5);

    // Not-taken branch costs nothing
    rom[2] = 9'h145; rom[3] = 9'h066; rom[4] = 9'h1F0;
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h145, 0);
    pushExp(10'h003, 9'h066, 0);
    pushExp(10'h004, 9'h1F0, 0);
    applyStimulus();
    waitDone(40);
    waitDrain(5);

    // LUT write colliding with a branch through the same index
    rom[2] = 9'h155; rom[3] = 9'h1F0; rom[10'h040] = 9'h155; rom[10'h080] = 9'h1F0;
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h155, 0);
    pushExp(10'h040, 9'h155, 1);
    pushExp(10'h080, 9'h1F0, 1);
    applyStimulus();
    waitValidPc(10'h002, 20);
    i_lut_we    = 1'b1;
    i_lut_waddr = 4'd5;
    i_lut_wdata = 10'h080;
    @(negedge i_clk);
    i_lut_we    = 1'b0;
    waitDone(40);
    waitDrain(5);

    // Branch to the top of the address space and wrap
    writeLut(4'd1, 10'h3FE);
    rom[2] = 9'h151; rom[10'h3FE] = 9'h033; rom[10'h3FF] = 9'h044;
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h151, 0);
    pushExp(10'h3FE, 9'h033, 1);
    pushExp(10'h3FF, 9'h044, 0);
    pushExp(10'h000, 9'h011, 0);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h1F0, 0);
    applyStimulus();
    waitValidPc(10'h002, 20);
    rom[2] = 9'h1F0;
    waitDone(40);
    waitDrain(5);
`ifdef FETCH_PERF_EN
    checkOutput("retiredCnt", {16'd0, o_retired_cnt}, 32'd8);
    checkOutput("bubbleCnt", {16'd0, o_bubble_cnt}, 32'd1);
`endif

    // Reset asserted while in FLUSH; LUT must come back cleared
    rom[2] = 9'h155;
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h155, 0);
    applyStimulus();
    waitValidPc(10'h002, 20);
    @(posedge i_clk);
    #1;
    checkOutput("flushAddr", {22'd0, o_imem_addr}, 32'h080);
    checkOutput("flushValid", {31'd0, o_instr_valid}, 32'd0);
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, o_instr_valid}, 32'd0);
    checkOutput("midRstAddr", {22'd0, o_imem_addr}, 32'd0);
    checkOutput("midRstDone", {31'd0, o_done}, 32'd0);
    checkOutput("midRstInstrPc", {22'd0, o_instr_pc}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    checkOutput("postRstQueue", expQ.size(), 32'd0);
    pushExp(10'h000, 9'h011, -1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h155, 0);
    pushExp(10'h000, 9'h011, 1);
    pushExp(10'h001, 9'h022, 0);
    pushExp(10'h002, 9'h1F0, 0);
    applyStimulus();
    waitValidPc(10'h002, 20);
    rom[2] = 9'h1F0;
    waitDone(40);
    waitDrain(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control decoder.
- Holds the program counter and drives a synchronous instruction ROM with 1-cycle read latency.
- Presents the 9-bit instruction and a valid flag to the decoder, and consumes the decoder's Branch and pc_immed outputs.
- Taken branches redirect through a 16-entry loadable branch-target LUT. A start/done handshake frames program execution.

Parameters:
- PC_W, 10, program counter / instruction ROM address width
- INSTR_W, 9, instruction width
- LUT_IDX_W, 4, branch-target LUT index width (2^LUT_IDX_W entries; matches pc_immed)
- HALT_WORD, 9'b111_11_0000, halt encoding; matched on instr[8:4] only (opcode 111, funct 11)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins execution at PC 0
- imem_addr  out  PC_W  instruction ROM address (registered)
- imem_rdata  in  INSTR_W  ROM data; valid 1 cycle after imem_addr
- instr  out  INSTR_W  instruction to decoder; equals imem_rdata
- instr_valid  out  1  instr is architecturally live; decoder must suppress RegWrite/MemWrite when 0
- instr_pc  out  PC_W  address of the instruction currently on instr
- Branch  in  1  taken-branch indication from decoder, combinational in the same cycle
- pc_immed  in  LUT_IDX_W  LUT index for the branch target
- lut_we  in  1  LUT write enable
- lut_waddr  in  LUT_IDX_W  LUT write index
- lut_wdata  in  PC_W  LUT write data (target PC)
- done  out  1  high while in DONE

Behaviour:
- Reset value (asynchronous, rst_n=0): state=IDLE; fetch_pc=0; instr_pc=0; instr_valid=0; done=0; all LUT entries=0. imem_addr=fetch_pc=0.
- States: IDLE, PRIME, RUN, FLUSH, DONE.
- IDLE: instr_valid=0. On start=1 -> PRIME, and fetch_pc stays 0.
- PRIME (one cycle, ROM reading addr 0): instr_valid=0; fetch_pc<=1; instr_pc<=0; -> RUN.
- RUN: instr_valid=1. Each edge:
  - Halt (instr[8:4]==HALT_WORD[8:4]) -> DONE. Highest priority; Branch is ignored.
  - Else if Branch=1: fetch_pc<=LUT[pc_immed] -> FLUSH.
  - Else: fetch_pc<=fetch_pc+1; instr_pc<=fetch_pc; stay in RUN.
- FLUSH (one cycle): instr_valid=0, because the wrong-path word from the old fetch_pc is squashed. instr_pc<=fetch_pc (the target); fetch_pc<=fetch_pc+1 -> RUN.
- Branch timing:
  - Taken-branch penalty is exactly 1 bubble cycle.
  - Not-taken branches cost 0 cycles.
  - Branch and pc_immed are sampled only in RUN; they are ignored in all other states.
- DONE: done=1; instr_valid=0; PC frozen. On start=1 -> fetch_pc<=0, done<=0 -> PRIME.
- start is ignored in PRIME, RUN and FLUSH.
- PC arithmetic: fetch_pc increments modulo 2^PC_W (0x3FF -> 0x000); no error flag. A LUT target is used verbatim.
- LUT:
  - Write is synchronous on lut_we, in any state.
  - Read is combinational.
  - Write and branch to the same index in the same cycle: the branch uses the old entry; the new value is visible from the next cycle.
- Reset asserted mid-operation (including FLUSH): outputs return to reset values immediately, and the LUT is cleared.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs retired_cnt (16-bit) and bubble_cnt (16-bit), cleared by reset and on each start.
  - retired_cnt increments on every RUN cycle with instr_valid=1, halt included.
  - bubble_cnt increments on every FLUSH cycle.
  - Both saturate at 0xFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset/start/halt: ROM[0..2]=ALU ops, ROM[3]=halt; start pulse at cycle 0 -> instr_valid in cycles 2-5 with instr_pc 0,1,2,3; done=1 from cycle 6; imem_addr frozen.
- Taken branch: LUT[5]=0x040; ROM[2] is a branch with the decoder driving Branch=1, pc_immed=5 -> sequence instr_pc 2, bubble (instr_valid=0), 0x040, 0x041.
- Not-taken branch: Branch=0 at instr_pc 2 -> instr_pc 3 on the next cycle with no bubble.
- LUT write collision: LUT[5]=0x040, then lut_we with lut_waddr=5, lut_wdata=0x080 in the same cycle as a taken branch via index 5 -> target 0x040; a later branch via 5 -> target 0x080.
- Reset during FLUSH: rst_n low mid-cycle -> instr_valid=0, imem_addr=0, done=0 immediately, LUT reads 0; after a new start, fetch resumes at PC 0.
- Wrap: LUT[1]=0x3FE, branch via index 1, no halt -> instr_pc 0x3FE, 0x3FF, 0x000, 0x001. With FETCH_PERF_EN defined, bubble_cnt=1.
